instruction_fetch: RTL
======================

# instruction_fetch

- Fetch stage between the program counter and decode.
- Keeps its own fetch address, starting at the same reset value as the PC, and issues in-order 32-bit reads to the instruction memory port.
- Buffers returned words with their addresses in a small FIFO and presents them to decode with a valid/ready handshake.
- A redirect from execute flushes buffered and in-flight fetches and restarts at the new address.

## Interface
- `FIFO_DEPTH`, default 4: instruction buffer entries; power of two, ≥2. It also caps outstanding reads.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `redirect` in 1: execute is writing a new PC this cycle.
- `redirect_addr` in 32: new fetch address, word aligned.
- `mem_read_enable` out 1: read request valid.
- `mem_read_addr` out 32: request address.
- `mem_ready` in 1: request accepted this cycle.
- `mem_read_data_valid` in 1: response valid. Responses return in order, with latency ≥1 cycle after acceptance.
- `mem_read_data` in 32: response word.
- `instr_valid` out 1: FIFO head valid.
- `instr` out 32: head instruction word.
- `instr_pc` out 32: head instruction address.
- `instr_ready` in 1: decode pops the head when this and `instr_valid` are both high.

## Operation
- Registered state:
  - `fetch_addr`
  - `outstanding` (accepted reads not yet returned)
  - `discard` (returns still to be dropped)
  - FIFO
- Credit rule: `credit = FIFO_DEPTH - fifo_count - (outstanding - discard)`, computed from registered state only.
- Request issue:
  - `mem_read_enable` = `credit > 0` and not `redirect`.
  - `mem_read_addr` = `fetch_addr`.
  - On acceptance (`mem_read_enable` and `mem_ready`): `fetch_addr += 4` (wraps modulo 2^32) and `outstanding += 1`.
- Response handling:
  - Each `mem_read_data_valid` decrements `outstanding`.
  - If `discard > 0`, the word is dropped and `discard -= 1`.
  - Otherwise `{addr, word}` is pushed. The push address comes from a return-address register that advances by 4 per kept response.
  - The credit rule guarantees the FIFO never overflows and responses are never back-pressured.
- Redirect in cycle N:
  - FIFO cleared; `instr_valid` is low in N+1.
  - `fetch_addr` and the return-address register both load `redirect_addr`.
  - `discard` loads the outstanding count after cycle N, excluding a response arriving in N, which is itself dropped.
  - A pop in the same cycle is ignored; redirect wins.
  - No request is issued in N.
- Push and pop in the same cycle on a full FIFO are legal, because the credit rule already excludes the slot.
- `redirect_addr[1:0]` is ignored (forced to 0).

## Timing
- Reset values:
  - `fetch_addr` = 0x1000_0000.
  - return-address register = 0x1000_0000.
  - `mem_read_enable` = 0.
  - `instr_valid` = 0.
  - `instr` = 0.
  - `instr_pc` = 0.
  - `outstanding` and `discard` = 0.
- After reset deasserts, the first request is issued in the first clocked cycle.
- The FIFO is registered with no bypass. A response in cycle M gives `instr_valid` in M+1.
- Redirect latency: redirect in N, new-address request in N+1, earliest response in N+2, `instr_valid` in N+3.
- A pop in cycle P frees credit starting at P+1. There is no combinational path from `instr_ready` or `mem_ready` to `mem_read_enable`.
- Reset asserted mid-operation returns all state to reset values immediately. Memory responses to pre-reset requests are the memory's responsibility: it is reset by the same signal.

## Configuration
- Macro `FETCH_PERF_COUNTERS_EN`.
- Defined: adds two 32-bit outputs, both reset to 0 and wrapping on overflow:
  - `perf_fetch_stall_cycles`: cycles with `credit == 0`.
  - `perf_discarded_words`: dropped responses.
- Undefined: the ports and counters do not exist. Functional behaviour is identical either way.

## Structure
- Shared package `cpu_pkg`:
  - `RESET_PC` = 32'h1000_0000, used by both the PC and fetch.
  - `fetch_entry_t` struct `{logic [31:0] pc; logic [31:0] instr;}`.
- Sub-module `fetch_fifo`:
  - Parameterised depth.
  - Push, pop, synchronous clear, count output, registered head.
- Credit, discard, and address logic stay in `instruction_fetch`.

## Test plan
- **Reset then stream:** 1-cycle memory with constant `mem_ready` = 1 and `instr_ready` = 1 → `instr_pc` sequence 0x1000_0000, 0x1000_0004, 0x1000_0008… with no gaps in steady state.
- **Back-pressure:** `instr_ready` = 0 for 20 cycles (`FIFO_DEPTH` = 4) → exactly 4 requests issued, then `mem_read_enable` stays low. Releasing `instr_ready` resumes issue on the cycle after the first pop.
- **Redirect with 2 in flight:** 3-cycle memory latency, redirect to 0x2000_0040 → the 2 old words are dropped, and the next `instr_pc` is 0x2000_0040 with that address's data.
- **Redirect coincident with a response and a pop** → the response is dropped, the FIFO ends empty, and `perf_discarded_words` (if enabled) is incremented by the total dropped.
- **Address wrap:** redirect to 0xFFFF_FFFC → `instr_pc` values 0xFFFF_FFFC then 0x0000_0000.
- **Reset mid-stream** with 2 outstanding and a full FIFO → `instr_valid` drops immediately, and after release fetching restarts at 0x1000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the program counter and the fetch stage.
// Holds the common reset PC, the fetch buffer entry type and a word-align helper.
package cpu_pkg;

    // Address that both the PC and the fetch stage start from after reset
    localparam logic [31:0] RESET_PC = 32'h1000_0000;

    // Width of the outstanding/discard read counters; the memory must never hold
    // more accepted-but-unreturned reads than this width can count
    localparam int OUTST_W = 16;

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force an address onto a 32-bit word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch stage: a power-of-two circular FIFO of
// {pc, instr} entries with push, pop, synchronous clear and an occupancy count.
// The head is read straight from the storage registers, so a word pushed in one
// cycle becomes visible at the head no earlier than the next cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pop_ok;

    // Compute next storage, pointers and count; clear overrides push and pop
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != '0);
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order word reads from its own fetch address, buffers the
// returned words with their addresses and hands them to decode via valid/ready.
// A redirect flushes the buffer, marks every in-flight read for discard and
// restarts fetching at the new (word-aligned) address.
// Reads are only issued while buffer space is guaranteed for them, so responses
// never need back-pressure.
// Optional feature macro: FETCH_PERF_COUNTERS_EN adds stall and discard counters.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        mem_read_enable,
    output logic [31:0] mem_read_addr,
    input  logic        mem_ready,
    input  logic        mem_read_data_valid,
    input  logic [31:0] mem_read_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetch_stall_cycles,
    output logic [31:0] perf_discarded_words
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]        fetch_addr_q, fetch_addr_d;
    logic [31:0]        ret_addr_q, ret_addr_d;
    logic [OUTST_W-1:0] outstanding_q, outstanding_d;
    logic [OUTST_W-1:0] discard_q, discard_d;

    logic [CNT_W-1:0]   fifo_count;
    logic [OUTST_W-1:0] live_reads;
    logic [OUTST_W:0]   used_slots;
    logic               has_credit;
    logic               req_accept;
    logic               rsp_drop;
    logic               fifo_push;
    logic               fifo_pop;
    logic               head_valid;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;
    logic [31:0]        redirect_target;

    // Credit: buffer slots not yet promised to queued words or live reads
    always_comb begin
        live_reads = outstanding_q - discard_q;
        used_slots = {1'b0, live_reads} + (OUTST_W + 1)'(fifo_count);
        has_credit = used_slots < (OUTST_W + 1)'(FIFO_DEPTH);
    end

    assign mem_read_enable = has_credit && !redirect && !reset;
    assign mem_read_addr   = fetch_addr_q;

    // Classify this cycle's request, response and decode handshakes
    always_comb begin
        req_accept      = mem_read_enable && mem_ready;
        rsp_drop        = mem_read_data_valid && (redirect || (discard_q != '0));
        fifo_push       = mem_read_data_valid && !rsp_drop;
        fifo_pop        = head_valid && instr_ready && !redirect;
        push_entry      = '{pc: ret_addr_q, instr: mem_read_data};
        redirect_target = word_align(redirect_addr);
    end

    // Next fetch/return addresses and read bookkeeping; redirect takes priority
    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        ret_addr_d    = ret_addr_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + OUTST_W'(req_accept) - OUTST_W'(mem_read_data_valid);
        if (redirect) begin
            fetch_addr_d = redirect_target;
            ret_addr_d   = redirect_target;
            discard_d    = outstanding_q - OUTST_W'(mem_read_data_valid);
        end else begin
            if (req_accept) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
            end
            if (fifo_push) begin
                ret_addr_d = ret_addr_q + 32'd4;
            end
            if (mem_read_data_valid && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
        end
    end

    // Address and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr_q  <= RESET_PC;
            ret_addr_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            ret_addr_q    <= ret_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect),
        .push       (fifo_push),
        .push_data  (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign instr_valid = head_valid;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Count credit-starved cycles and dropped responses, wrapping on overflow
    always_comb begin
        stall_cnt_d = stall_cnt_q + (has_credit ? 32'd0 : 32'd1);
        drop_cnt_d  = drop_cnt_q + (rsp_drop ? 32'd1 : 32'd0);
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign perf_fetch_stall_cycles = stall_cnt_q;
    assign perf_discarded_words    = drop_cnt_q;
`endif

endmodule
